// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - debounced, blank-interval handover of HEX/LEDR between display units A and B
module display_arbiter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLANK_CYCLES    = 2500000,
  parameter int DWELL_CYCLES    = 100000000
) (
  input  logic        MAX10_CLK1_50,
  input  logic        reset_n,
  input  logic        sel_raw,
  input  logic        auto_en,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [47:0] hex_a,
  input  logic [47:0] hex_b,
  input  logic [9:0]  ledr_a,
  input  logic [9:0]  ledr_b,
  output logic [47:0] HEX,
  output logic [9:0]  LEDR,
  output logic        grant_a,
  output logic        grant_b,
  output logic        busy
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    OWN_A = 2'd0,
    OWN_B = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            target;
  logic            target_nx;
  logic            sync1;
  logic            sync2;
  logic            sel_db;
  logic [DB_W-1:0] db_cnt;
  logic [BL_W-1:0] blank_cnt;
  logic [DW_W-1:0] dwell_cnt;
  logic            blank_last;
  logic            dwell_tc;
  logic            desired;
  logic [47:0]     hex_nx;
  logic [9:0]      ledr_nx;
  logic            grant_a_nx;
  logic            grant_b_nx;
  logic            busy_nx;

  assign blank_last = (blank_cnt == BL_LAST);
  assign dwell_tc   = (dwell_cnt == DW_LAST);

  // sel_db only moves after DEBOUNCE_CYCLES unbroken cycles of disagreement
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sel_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= sel_raw;
      sync2 <= sync1;
      if (sync2 == sel_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        sel_db <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Desired owner: 0 = A, 1 = B
  always_comb begin
    desired = sel_db;
    if (auto_en) begin
      case (state)
        OWN_A:   desired = dwell_tc && req_b;
        OWN_B:   desired = !(dwell_tc && req_a);
        default: begin
          if (!req_a && !req_b) begin
            desired = 1'b0;
          end else if (target ? req_b : req_a) begin
            desired = target;
          end else begin
            desired = ~target;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    target_nx  = target;
    hex_nx     = {48{1'b1}};
    ledr_nx    = '0;
    grant_a_nx = 1'b0;
    grant_b_nx = 1'b0;
    busy_nx    = 1'b1;
    case (state)
      OWN_A: begin
        if (desired) begin
          state_nx  = BLANK;
          target_nx = desired;
        end
      end
      OWN_B: begin
        if (!desired) begin
          state_nx  = BLANK;
          target_nx = desired;
        end
      end
      BLANK: begin
        if (blank_last) begin
          state_nx  = desired ? OWN_B : OWN_A;
          target_nx = desired;
        end
      end
      default: state_nx = BLANK;
    endcase
    if (state_nx == OWN_A) begin
      hex_nx     = hex_a;
      ledr_nx    = ledr_a;
      grant_a_nx = 1'b1;
      busy_nx    = 1'b0;
    end else if (state_nx == OWN_B) begin
      hex_nx     = hex_b;
      ledr_nx    = ledr_b;
      grant_b_nx = 1'b1;
      busy_nx    = 1'b0;
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      state   <= BLANK;
      target  <= 1'b0;
      HEX     <= {48{1'b1}};
      LEDR    <= '0;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nx;
      target  <= target_nx;
      HEX     <= hex_nx;
      LEDR    <= ledr_nx;
      grant_a <= grant_a_nx;
      grant_b <= grant_b_nx;
      busy    <= busy_nx;
    end
  end

  // Dwell restarts at its terminal count and is held at 0 across any BLANK
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset_n) begin
      blank_cnt <= '0;
      dwell_cnt <= '0;
    end else begin
      if (state == BLANK && !blank_last) begin
        blank_cnt <= blank_cnt + BL_W'(1);
      end else begin
        blank_cnt <= '0;
      end
      if (state != BLANK && state_nx != BLANK && !dwell_tc) begin
        dwell_cnt <= dwell_cnt + DW_W'(1);
      end else begin
        dwell_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - scoreboard bench for display_arbiter with directed per-cycle expectations
module tb_display_arbiter;

  localparam int K_A  = 0;
  localparam int K_B  = 1;
  localparam int K_BL = 2;

  typedef struct {
    logic [47:0] hex;
    logic [9:0]  ledr;
    logic        ga;
    logic        gb;
    logic        busy;
    int          tag;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        sel_raw;
  logic        auto_en;
  logic        req_a;
  logic        req_b;
  logic [47:0] hex_a;
  logic [47:0] hex_b;
  logic [9:0]  ledr_a;
  logic [9:0]  ledr_b;
  logic [47:0] HEX;
  logic [9:0]  LEDR;
  logic        grant_a;
  logic        grant_b;
  logic        busy;

  exp_t sb[$];
  exp_t cur;
  int   checks;
  int   failures;
  int   step_no;

  display_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .BLANK_CYCLES   (3),
    .DWELL_CYCLES   (8)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset_n      (reset_n),
    .sel_raw      (sel_raw),
    .auto_en      (auto_en),
    .req_a        (req_a),
    .req_b        (req_b),
    .hex_a        (hex_a),
    .hex_b        (hex_b),
    .ledr_a       (ledr_a),
    .ledr_b       (ledr_b),
    .HEX          (HEX),
    .LEDR         (LEDR),
    .grant_a      (grant_a),
    .grant_b      (grant_b),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with inputs already set; records what the next posedge must produce.
  task automatic step(input int kind);
    exp_t e;
    e.tag = step_no;
    if (kind == K_A) begin
      e.hex = hex_a; e.ledr = ledr_a; e.ga = 1'b1; e.gb = 1'b0; e.busy = 1'b0;
    end else if (kind == K_B) begin
      e.hex = hex_b; e.ledr = ledr_b; e.ga = 1'b0; e.gb = 1'b1; e.busy = 1'b0;
    end else begin
      e.hex = 48'hFFFF_FFFF_FFFF; e.ledr = 10'h000; e.ga = 1'b0; e.gb = 1'b0; e.busy = 1'b1;
    end
    sb.push_back(e);
    step_no++;
    @(negedge clk);
  endtask

  task automatic steps(input int kind, input int n);
    for (int i = 0; i < n; i++) step(kind);
  endtask

  always @(posedge clk) begin
    #1;
    checks++;
    if ((grant_a & grant_b) !== 1'b0) begin
      failures++;
      $display("FAIL grant_excl t=%0t grant_a=%b grant_b=%b required not both", $time, grant_a, grant_b);
    end
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (HEX !== cur.hex || LEDR !== cur.ledr || grant_a !== cur.ga ||
          grant_b !== cur.gb || busy !== cur.busy) begin
        failures++;
        $display("FAIL step%0d got HEX=%h LEDR=%h ga=%b gb=%b busy=%b required HEX=%h LEDR=%h ga=%b gb=%b busy=%b",
                 cur.tag, HEX, LEDR, grant_a, grant_b, busy,
                 cur.hex, cur.ledr, cur.ga, cur.gb, cur.busy);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    step_no  = 0;
    reset_n  = 1'b0;
    sel_raw  = 1'b0;
    auto_en  = 1'b0;
    req_a    = 1'b0;
    req_b    = 1'b0;
    hex_a    = 48'h0123456789AB;
    hex_b    = 48'hFEDCBA987654;
    ledr_a   = 10'h155;
    ledr_b   = 10'h2AA;
    @(negedge clk);

    // Reset, then 3-cycle blank, then A with 1-cycle data latency
    reset_n = 1'b0; steps(K_BL, 2);
    reset_n = 1'b1; steps(K_BL, 2);
    steps(K_A, 3);
    hex_a = 48'hA5A50F0F1234; ledr_a = 10'h3C1; steps(K_A, 2);

    // Manual A->B: blank entered 7 cycles after sel_raw edge
    sel_raw = 1'b1; steps(K_A, 6); steps(K_BL, 3); steps(K_B, 3);
    hex_b = 48'h00FF00FF00FF; ledr_b = 10'h0F0; steps(K_B, 1);
    sel_raw = 1'b0; steps(K_B, 6); steps(K_BL, 3); steps(K_A, 3);

    // 3-cycle glitch is rejected
    sel_raw = 1'b1; steps(K_A, 3);
    sel_raw = 1'b0; steps(K_A, 8);

    // Reset on the 2nd blank cycle of an A->B switch
    sel_raw = 1'b1; steps(K_A, 6); steps(K_BL, 1);
    reset_n = 1'b0; sel_raw = 1'b0; steps(K_BL, 1);
    reset_n = 1'b1; steps(K_BL, 2); steps(K_A, 3);

    // Auto rotation with both units requesting
    auto_en = 1'b1; req_a = 1'b1; req_b = 1'b1;
    reset_n = 1'b0; steps(K_BL, 2);
    reset_n = 1'b1; steps(K_BL, 2);
    steps(K_A, 8); steps(K_BL, 3); steps(K_B, 8); steps(K_BL, 3);
    steps(K_A, 8); steps(K_BL, 3); steps(K_B, 8); steps(K_BL, 3);

    // Auto skip: B idle, A holds across several dwells
    req_b = 1'b0; steps(K_A, 20);

    // Leaving auto with sel_db already at B forces an immediate blank
    sel_raw = 1'b1; steps(K_A, 8);
    auto_en = 1'b0; steps(K_BL, 3); steps(K_B, 2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
